// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode map, ALU/shift codes, control FSM states
// and the registered control bundle.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SHIFT_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_LOADI = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_MOV   = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_AND   = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_OR    = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_J     = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_LWD   = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_LWI   = 8'h09;
    localparam logic [OPCODE_W-1:0] OP_SWD   = 8'h0A;
    localparam logic [OPCODE_W-1:0] OP_SWI   = 8'h0B;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 8'h0C;
    localparam logic [OPCODE_W-1:0] OP_SLL   = 8'h0D;
    localparam logic [OPCODE_W-1:0] OP_SRL   = 8'h0E;
    localparam logic [OPCODE_W-1:0] OP_SRA   = 8'h0F;
    localparam logic [OPCODE_W-1:0] OP_ROR   = 8'h10;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 8'h11;

    localparam logic [ALUOP_W-1:0] ALU_FWD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_MUL   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SHIFT = 3'b101;

    localparam logic [SHIFT_W-1:0] SH_SLL = 2'b00;
    localparam logic [SHIFT_W-1:0] SH_SRL = 2'b01;
    localparam logic [SHIFT_W-1:0] SH_SRA = 2'b10;
    localparam logic [SHIFT_W-1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_DECODE = 2'd0,
        ST_MEM    = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    typedef struct packed {
        logic               we;
        logic [ALUOP_W-1:0] aluop;
        logic               reg2_sign_sel;
        logic               op2_sel;
        logic [SHIFT_W-1:0] shift_mode;
        logic               jump;
        logic               branch;
        logic               branch_ne;
        logic               mem_read;
        logic               mem_write;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode into the datapath control bundle plus
// memory/load classification and an illegal-opcode indication.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl_c,
    output logic                is_mem_c,
    output logic                is_load_c,
    output logic                illegal_c
);

    always_comb begin
        ctrl_c    = '0;
        is_mem_c  = 1'b0;
        is_load_c = 1'b0;
        illegal_c = 1'b0;
        case (opcode)
            OP_LOADI: begin ctrl_c.we = 1'b1; ctrl_c.op2_sel = 1'b1; end
            OP_MOV:   ctrl_c.we = 1'b1;
            OP_ADD:   begin ctrl_c.we = 1'b1; ctrl_c.aluop = ALU_ADD; end
            OP_SUB: begin
                ctrl_c.we            = 1'b1;
                ctrl_c.aluop         = ALU_ADD;
                ctrl_c.reg2_sign_sel = 1'b1;
            end
            OP_AND:   begin ctrl_c.we = 1'b1; ctrl_c.aluop = ALU_AND; end
            OP_OR:    begin ctrl_c.we = 1'b1; ctrl_c.aluop = ALU_OR;  end
            OP_MUL:   begin ctrl_c.we = 1'b1; ctrl_c.aluop = ALU_MUL; end
            OP_J:     ctrl_c.jump = 1'b1;
            OP_BEQ, OP_BNE: begin
                ctrl_c.aluop         = ALU_ADD;
                ctrl_c.reg2_sign_sel = 1'b1;
                ctrl_c.branch        = (opcode == OP_BEQ);
                ctrl_c.branch_ne     = (opcode == OP_BNE);
            end
            // Address is base plus register (d forms) or immediate (i forms)
            OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                ctrl_c.aluop     = ALU_ADD;
                ctrl_c.op2_sel   = (opcode == OP_LWI) || (opcode == OP_SWI);
                ctrl_c.mem_read  = (opcode == OP_LWD) || (opcode == OP_LWI);
                ctrl_c.mem_write = (opcode == OP_SWD) || (opcode == OP_SWI);
                is_mem_c         = 1'b1;
                is_load_c        = ctrl_c.mem_read;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                ctrl_c.we      = 1'b1;
                ctrl_c.aluop   = ALU_SHIFT;
                ctrl_c.op2_sel = 1'b1;
                case (opcode)
                    OP_SLL:  ctrl_c.shift_mode = SH_SLL;
                    OP_SRL:  ctrl_c.shift_mode = SH_SRL;
                    OP_SRA:  ctrl_c.shift_mode = SH_SRA;
                    default: ctrl_c.shift_mode = SH_ROR;
                endcase
            end
            default:  illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Registered multi-cycle control unit: decodes accepted opcodes, sequences
// memory access / write-back and stalls the PC while data memory is busy.
module control_fsm
    import cpu_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                INSTR_VALID,
    input  logic                BUSYWAIT,
    output logic                WRITE_ENABLE,
    output logic [ALUOP_W-1:0]  ALUOP,
    output logic                REG2_SIGN_SEL,
    output logic                OP2_SEL,
    output logic [SHIFT_W-1:0]  SHIFT_MODE,
    output logic                JUMP,
    output logic                BRANCH,
    output logic                BRANCH_NE,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic                WB_SEL,
    output logic                PC_STALL,
    output logic                ILLEGAL
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   load_q, load_d;
    logic   pc_stall_q, pc_stall_d;
    logic   wb_sel_q, wb_sel_d;
    logic   illegal_q, illegal_d;

    ctrl_t  dec_ctrl_c;
    logic   dec_is_mem_c;
    logic   dec_is_load_c;
    logic   dec_illegal_c;

    opcode_decoder u_dec (
        .opcode    (OPCODE),
        .ctrl_c    (dec_ctrl_c),
        .is_mem_c  (dec_is_mem_c),
        .is_load_c (dec_is_load_c),
        .illegal_c (dec_illegal_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_DECODE;
            ctrl_q     <= '0;
            load_q     <= 1'b0;
            pc_stall_q <= 1'b0;
            wb_sel_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            pc_stall_q <= pc_stall_d;
            wb_sel_q   <= wb_sel_d;
            illegal_q  <= illegal_d;
        end
    end

    // Strobes default low each cycle; ALU select and operand muxes hold.
    always_comb begin
        state_d          = state_q;
        ctrl_d           = ctrl_q;
        ctrl_d.we        = 1'b0;
        ctrl_d.jump      = 1'b0;
        ctrl_d.branch    = 1'b0;
        ctrl_d.branch_ne = 1'b0;
        ctrl_d.mem_read  = 1'b0;
        ctrl_d.mem_write = 1'b0;
        load_d           = load_q;
        pc_stall_d       = 1'b0;
        wb_sel_d         = 1'b0;
        illegal_d        = illegal_q;
        case (state_q)
            ST_DECODE: begin
                if (INSTR_VALID) begin
                    ctrl_d    = dec_ctrl_c;
                    load_d    = dec_is_load_c;
                    illegal_d = illegal_q | dec_illegal_c;
                    if (dec_is_mem_c) begin
                        state_d    = ST_MEM;
                        pc_stall_d = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (BUSYWAIT) begin
                    ctrl_d.mem_read  = ctrl_q.mem_read;
                    ctrl_d.mem_write = ctrl_q.mem_write;
                    pc_stall_d       = 1'b1;
                end else if (load_q) begin
                    state_d   = ST_WB;
                    ctrl_d.we = 1'b1;
                    wb_sel_d  = 1'b1;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_WB:   state_d = ST_DECODE;
            default: state_d = ST_DECODE;
        endcase
    end

    assign WRITE_ENABLE  = ctrl_q.we;
    assign ALUOP         = ctrl_q.aluop;
    assign REG2_SIGN_SEL = ctrl_q.reg2_sign_sel;
    assign OP2_SEL       = ctrl_q.op2_sel;
    assign SHIFT_MODE    = ctrl_q.shift_mode;
    assign JUMP          = ctrl_q.jump;
    assign BRANCH        = ctrl_q.branch;
    assign BRANCH_NE     = ctrl_q.branch_ne;
    assign MEM_READ      = ctrl_q.mem_read;
    assign MEM_WRITE     = ctrl_q.mem_write;
    assign WB_SEL        = wb_sel_q;
    assign PC_STALL      = pc_stall_q;
    assign ILLEGAL       = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed vector table for the documented scenarios,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_control_fsm;

    typedef struct packed {
        logic       we;
        logic [2:0] alu;
        logic       sgn;
        logic       op2;
        logic [1:0] sh;
        logic       j;
        logic       br;
        logic       bne;
        logic       rd;
        logic       wr;
        logic       wb;
        logic       st;
        logic       ill;
    } obs_t;

    typedef struct {
        bit         rst;
        bit         vld;
        logic [7:0] op;
        bit         bw;
        obs_t       exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] opcode = 8'h00;
    logic       vld = 1'b0;
    logic       bw = 1'b0;

    logic       we_o, jump_o, br_o, bne_o, rd_o, wr_o, wbsel_o, stall_o, ill_o;
    logic       sgn_o, op2_o;
    logic [2:0] alu_o;
    logic [1:0] sh_o;

    int n_pass = 0;
    int n_total = 0;

    control_fsm dut (
        .CLK           (clk),
        .RESET         (rst),
        .OPCODE        (opcode),
        .INSTR_VALID   (vld),
        .BUSYWAIT      (bw),
        .WRITE_ENABLE  (we_o),
        .ALUOP         (alu_o),
        .REG2_SIGN_SEL (sgn_o),
        .OP2_SEL       (op2_o),
        .SHIFT_MODE    (sh_o),
        .JUMP          (jump_o),
        .BRANCH        (br_o),
        .BRANCH_NE     (bne_o),
        .MEM_READ      (rd_o),
        .MEM_WRITE     (wr_o),
        .WB_SEL        (wbsel_o),
        .PC_STALL      (stall_o),
        .ILLEGAL       (ill_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input bit we, input logic [2:0] alu, input bit sgn,
                               input bit op2, input logic [1:0] sh, input bit j,
                               input bit br, input bit bne, input bit rd, input bit wr,
                               input bit wb, input bit st, input bit ill);
        obs_t r;
        r = {we, alu, sgn, op2, sh, j, br, bne, rd, wr, wb, st, ill};
        return r;
    endfunction

    function automatic obs_t actual();
        obs_t r;
        r = {we_o, alu_o, sgn_o, op2_o, sh_o, jump_o, br_o, bne_o,
             rd_o, wr_o, wbsel_o, stall_o, ill_o};
        return r;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h (we alu sgn op2 sh j br bne rd wr wb st ill) expected %h",
                      name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference controls straight from the opcode table.
    function automatic obs_t ref_ctrl(input logic [7:0] op, output bit is_mem,
                                      output bit is_ld, output bit bad);
        obs_t c;
        bit   shift;
        c      = '0;
        bad    = (op > 8'h11);
        is_mem = (op >= 8'h08) && (op <= 8'h0B);
        is_ld  = (op == 8'h08) || (op == 8'h09);
        shift  = (op >= 8'h0D) && (op <= 8'h10);
        if (bad) return c;
        c.we  = !(is_mem || op == 8'h06 || op == 8'h07 || op == 8'h11);
        if (op == 8'h04)      c.alu = 3'b010;
        else if (op == 8'h05) c.alu = 3'b011;
        else if (op == 8'h0C) c.alu = 3'b100;
        else if (shift)       c.alu = 3'b101;
        else if (op <= 8'h01 || op == 8'h06) c.alu = 3'b000;
        else                  c.alu = 3'b001;
        c.sgn = (op == 8'h03) || (op == 8'h07) || (op == 8'h11);
        c.op2 = (op == 8'h00) || (op == 8'h09) || (op == 8'h0B) || shift;
        c.sh  = shift ? 2'(op - 8'h0D) : 2'b00;
        c.j   = (op == 8'h06);
        c.br  = (op == 8'h07);
        c.bne = (op == 8'h11);
        c.rd  = is_ld;
        c.wr  = (op == 8'h0A) || (op == 8'h0B);
        return c;
    endfunction

    // Behavioural model: an outstanding memory access, then an optional write-back slot.
    obs_t m;
    bit   m_busy, m_ld, m_wb;

    task automatic model_edge(input bit r, input bit v, input logic [7:0] op, input bit b);
        obs_t c;
        bit   is_mem, is_ld, bad;
        if (r) begin
            m = '0; m_busy = 0; m_ld = 0; m_wb = 0;
            return;
        end
        if (m_busy && b) return;
        {m.we, m.j, m.br, m.bne, m.rd, m.wr, m.wb, m.st} = '0;
        if (m_wb) begin
            m_wb = 0;
        end else if (m_busy) begin
            m_busy = 0;
            if (m_ld) begin m.we = 1; m.wb = 1; m_wb = 1; end
        end else if (v) begin
            c = ref_ctrl(op, is_mem, is_ld, bad);
            c.ill = m.ill | bad;
            m = c;
            if (is_mem) begin m.st = 1; m_busy = 1; m_ld = is_ld; end
        end
    endtask

    vec_t vecs[$];

    task automatic add(input bit r, input bit v, input logic [7:0] op, input bit b,
                       input obs_t e, input string n);
        vec_t x;
        x.rst = r; x.vld = v; x.op = op; x.bw = b; x.exp = e; x.name = n;
        vecs.push_back(x);
    endtask

    initial begin
        add(1, 0, 8'h00, 0, o(0,3'b000,0,0,2'b00,0,0,0,0,0,0,0,0), "reset0");
        add(1, 0, 8'h00, 0, o(0,3'b000,0,0,2'b00,0,0,0,0,0,0,0,0), "reset1");
        add(0, 1, 8'h02, 0, o(1,3'b001,0,0,2'b00,0,0,0,0,0,0,0,0), "add");
        add(0, 1, 8'h03, 0, o(1,3'b001,1,0,2'b00,0,0,0,0,0,0,0,0), "sub");
        add(0, 0, 8'h03, 0, o(0,3'b001,1,0,2'b00,0,0,0,0,0,0,0,0), "idle_hold");
        add(0, 1, 8'h08, 1, o(0,3'b001,0,0,2'b00,0,0,0,1,0,0,1,0), "lwd_mem1");
        add(0, 1, 8'hFF, 1, o(0,3'b001,0,0,2'b00,0,0,0,1,0,0,1,0), "lwd_mem2");
        add(0, 1, 8'hFF, 1, o(0,3'b001,0,0,2'b00,0,0,0,1,0,0,1,0), "lwd_mem3");
        add(0, 1, 8'hFF, 0, o(1,3'b001,0,0,2'b00,0,0,0,0,0,1,0,0), "lwd_wb");
        add(0, 1, 8'h02, 0, o(0,3'b001,0,0,2'b00,0,0,0,0,0,0,0,0), "lwd_done");
        add(0, 1, 8'h0B, 0, o(0,3'b001,0,1,2'b00,0,0,0,0,1,0,1,0), "swi_mem");
        add(0, 0, 8'h00, 0, o(0,3'b001,0,1,2'b00,0,0,0,0,0,0,0,0), "swi_done");
        add(0, 1, 8'h11, 0, o(0,3'b001,1,0,2'b00,0,0,1,0,0,0,0,0), "bne");
        add(0, 1, 8'h06, 0, o(0,3'b000,0,0,2'b00,1,0,0,0,0,0,0,0), "j");
        add(0, 1, 8'h0F, 0, o(1,3'b101,0,1,2'b10,0,0,0,0,0,0,0,0), "sra");
        add(0, 1, 8'hFF, 0, o(0,3'b000,0,0,2'b00,0,0,0,0,0,0,0,1), "illegal");
        add(0, 1, 8'h02, 0, o(1,3'b001,0,0,2'b00,0,0,0,0,0,0,0,1), "add_after_ill");
        add(0, 0, 8'h02, 0, o(0,3'b001,0,0,2'b00,0,0,0,0,0,0,0,1), "ill_sticky");
        add(0, 1, 8'h09, 1, o(0,3'b001,0,1,2'b00,0,0,0,1,0,0,1,1), "lwi_mem1");
        add(0, 0, 8'h09, 1, o(0,3'b001,0,1,2'b00,0,0,0,1,0,0,1,1), "lwi_mem2");
        add(1, 0, 8'h09, 1, o(0,3'b000,0,0,2'b00,0,0,0,0,0,0,0,0), "reset_mid_mem");
        add(0, 1, 8'h01, 1, o(1,3'b000,0,0,2'b00,0,0,0,0,0,0,0,0), "mov_after_rst");
        add(0, 1, 8'h10, 0, o(1,3'b101,0,1,2'b11,0,0,0,0,0,0,0,0), "ror");

        foreach (vecs[i]) begin
            rst = vecs[i].rst; vld = vecs[i].vld; opcode = vecs[i].op; bw = vecs[i].bw;
            step();
            check(vecs[i].name, actual(), vecs[i].exp);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst    = (k < 2) || ($urandom_range(0, 79) == 0);
            vld    = ($urandom_range(0, 9) < 7);
            opcode = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h13));
            bw     = $urandom_range(0, 1) == 1;
            model_edge(rst, vld, opcode, bw);
            step();
            check($sformatf("rand%0d", k), actual(), m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Registered, multi-cycle control unit for the single-cycle-plus-memory CPU. It decodes the 8-bit OPCODE into datapath controls for the full ALU, branch, jump and data-memory instruction set. It stalls the PC while data memory asserts BUSYWAIT and flags illegal opcodes. It sits between the instruction register and the datapath (register file, ALU, operand muxes, PC logic, data-memory interface).

## Interface
- OPCODE_W, 8: opcode width.
- ALUOP_W, 3: ALU select width.
- SHIFT_W, 2: shift-mode width.
- CLK in 1: single clock, rising edge.
- RESET in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- OPCODE in OPCODE_W: current instruction opcode.
- INSTR_VALID in 1: OPCODE valid this cycle.
- BUSYWAIT in 1: data memory busy.
- WRITE_ENABLE out 1: register-file write strobe.
- ALUOP out ALUOP_W: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SHIFT.
- REG2_SIGN_SEL out 1: 1 = two's-complement negate operand 2.
- OP2_SEL out 1: 0 = reg2, 1 = immediate.
- SHIFT_MODE out SHIFT_W: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- JUMP out 1: unconditional jump.
- BRANCH out 1: branch if ZERO.
- BRANCH_NE out 1: branch if not ZERO.
- MEM_READ out 1: data-memory read request.
- MEM_WRITE out 1: data-memory write request.
- WB_SEL out 1: 0 = ALU result, 1 = memory data.
- PC_STALL out 1: hold PC and instruction register.
- ILLEGAL out 1: sticky undecodable-opcode flag.

## Operation
- Opcode map:
  - 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or, 06 j, 07 beq.
  - 08 lwd, 09 lwi, 0A swd, 0B swi.
  - 0C mul, 0D sll, 0E srl, 0F sra, 10 ror, 11 bne.
  - All other values are illegal.
- Control settings per class:
  - loadi: WE=1, ALUOP=000, OP2_SEL=1, REG2_SIGN_SEL=0.
  - sub: ALUOP=001, REG2_SIGN_SEL=1.
  - Shifts: ALUOP=101, OP2_SEL=1, SHIFT_MODE per opcode.
  - beq/bne: ALUOP=001, REG2_SIGN_SEL=1, WE=0.
  - j: JUMP=1, WE=0.
  - *i memory forms: OP2_SEL=1 (immediate address). *d forms: OP2_SEL=0.
- FSM states and transitions:
  - DECODE → MEM when INSTR_VALID and the opcode is a load/store; stays in DECODE otherwise.
  - MEM → WB when BUSYWAIT=0 and the op is a load.
  - MEM → DECODE when BUSYWAIT=0 and the op is a store.
  - WB → DECODE unconditionally.
- DECODE with INSTR_VALID and a non-memory opcode: controls register next edge and stay for exactly one cycle. After that, WE, JUMP, BRANCH, BRANCH_NE, MEM_* and ILLEGAL-pulse effects deassert unless a new valid opcode follows.
- MEM: MEM_READ or MEM_WRITE held high, and PC_STALL=1, until BUSYWAIT is sampled low. Requests drop on the edge BUSYWAIT is seen low.
- WB (loads only): WRITE_ENABLE=1, WB_SEL=1, PC_STALL=0 for one cycle.
- Illegal opcode: all strobes 0, ALUOP=000, ILLEGAL set, state stays DECODE. ILLEGAL clears only on RESET.
- INSTR_VALID=0 in DECODE: all strobes 0; ALUOP and muxes hold their previous values.
- OPCODE changes during MEM/WB are ignored. The opcode is latched at DECODE acceptance.

## Timing
- Reset: state=DECODE and every output is 0, including ALUOP=000, SHIFT_MODE=00, PC_STALL=0 and ILLEGAL=0.
- RESET overrides everything in the same edge, including mid-MEM. Memory requests drop on that edge.
- Latency:
  - ALU/branch/jump instructions: 1 cycle, opcode sampled to controls valid.
  - Loads: 1 + N + 1 cycles, where N ≥ 1 is the number of BUSYWAIT-high cycles.
  - Stores: 1 + N cycles.
- PC_STALL rises in the same cycle MEM_READ/MEM_WRITE rises. It falls on the edge the FSM leaves MEM.
- BUSYWAIT already low on the first MEM cycle gives N=1; a request is always at least one cycle wide.
- BUSYWAIT is ignored outside MEM.

## Structure
- The shared package `cpu_pkg` holds:
  - Opcode localparams (OP_LOADI … OP_BNE).
  - ALUOP codes (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_MUL, ALU_SHIFT).
  - SHIFT_MODE codes.
  - FSM state encoding (ST_DECODE, ST_MEM, ST_WB).
- One sub-module, `opcode_decoder`: purely combinational opcode → control-bundle plus is_mem, is_load and illegal. `control_fsm` registers its outputs and sequences them.

## Test plan
- ALU ops: RESET for 2 cycles → all outputs 0. Then OPCODE=02 valid → next edge WE=1, ALUOP=001, REG2_SIGN_SEL=0, OP2_SEL=0. OPCODE=03 → REG2_SIGN_SEL=1.
- Load: lwd (08) with BUSYWAIT high for 3 cycles → MEM_READ=1 and PC_STALL=1 for 3 cycles. Then one WB cycle with WE=1, WB_SEL=1. Then DECODE.
- Store: swi (0B) with BUSYWAIT low immediately → MEM_WRITE=1 for exactly 1 cycle, OP2_SEL=1, WE never asserted.
- Branch, jump and shift: bne (11) → BRANCH_NE=1, ALUOP=001, REG2_SIGN_SEL=1, WE=0. j (06) → JUMP=1. sra (0F) → ALUOP=101, SHIFT_MODE=10.
- Illegal opcode: OPCODE=FF valid → ILLEGAL=1 and all strobes 0. A following add still decodes and ILLEGAL remains 1 until RESET.
- Reset mid-stall: RESET asserted during MEM with BUSYWAIT=1 → next edge MEM_READ=0, PC_STALL=0, state DECODE.
